// File: rtl/tb_test_end_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_test_end_monitor                                           |
// | Purpose  : Multi-channel end-of-test monitor. It counts write_tohost      |
// |            retires, samples the result register and reports pass/fail.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_test_end_monitor #(
  parameter int                XLEN          = 64,
  parameter int                RETIRE_CH     = 2,
  parameter int                CNT_W         = 32,
  parameter int                TOHOST_THRESH = 8,
  parameter int                HOLDOFF_CYC   = 60,
  parameter int                DRAIN_CYC     = 1,
  parameter int                TIMEOUT_CYC   = 1000000,
  parameter logic [XLEN-1:0]   PASS_VAL      = {{(XLEN-1){1'b0}}, 1'b1}
) (
  input  logic                      tb_clk,
  input  logic                      tb_rst,
  input  logic [RETIRE_CH-1:0]      retire_vld,
  input  logic [RETIRE_CH*XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0]           tohost_pc,
  input  logic [XLEN-1:0]           result_reg,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instr_cnt,
  output logic [CNT_W-1:0]          tohost_cnt,
  output logic [CNT_W-1:0]          end_cycle,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout
);

  localparam int c_pop_w   = $clog2(RETIRE_CH + 1);
  localparam int c_hold_w  = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam int c_drain_w = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
  localparam logic [CNT_W:0]       c_thresh     = (CNT_W+1)'(TOHOST_THRESH);
  localparam logic [CNT_W-1:0]     c_timeout    = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]     c_one        = CNT_W'(1);

  // A timeout value the saturating cycle counter can never reach acts as disabled.
  localparam bit c_tmo_reach = (CNT_W >= 63) || (64'(TIMEOUT_CYC) < (64'(1) << CNT_W));
  localparam bit c_tmo_en    = (TIMEOUT_CYC != 0) && c_tmo_reach;

  typedef enum logic [1:0] {
    ST_HOLDOFF = 2'd0,
    ST_RUN     = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [c_hold_w-1:0]   hold_cnt_q, hold_cnt_d;
  logic [c_drain_w-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]      instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0]      tohost_cnt_q, tohost_cnt_d;
  logic [CNT_W-1:0]      end_cycle_q, end_cycle_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;

  logic [RETIRE_CH-1:0]  hit;
  logic [c_pop_w-1:0]    vld_pop;
  logic [c_pop_w-1:0]    hit_pop;
  logic [CNT_W-1:0]      cycle_nxt;
  logic [CNT_W-1:0]      instr_nxt;
  logic [CNT_W-1:0]      tohost_nxt;
  logic                  thresh_hit;
  logic                  tmo_hit;
  logic                  result_ok;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // The valid strobe gates the compare so an undefined PC on an idle channel cannot count.
  generate
    for (genvar i = 0; i < RETIRE_CH; i++) begin : g_ch
      assign hit[i] = retire_vld[i] && (retire_pc[i*XLEN +: XLEN] == tohost_pc);
    end
  endgenerate

  always_comb begin
    vld_pop = '0;
    hit_pop = '0;
    for (int i = 0; i < RETIRE_CH; i++) begin
      vld_pop = vld_pop + c_pop_w'(retire_vld[i]);
      hit_pop = hit_pop + c_pop_w'(hit[i]);
    end
  end

  assign cycle_nxt  = sat_add(cycle_cnt_q, c_one);
  assign instr_nxt  = sat_add(instr_cnt_q, CNT_W'(vld_pop));
  assign tohost_nxt = sat_add(tohost_cnt_q, CNT_W'(hit_pop));
  assign thresh_hit = ({1'b0, tohost_nxt} >= c_thresh);
  assign tmo_hit    = c_tmo_en && (cycle_nxt == c_timeout);
  assign result_ok  = (result_reg == PASS_VAL);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;
    tohost_cnt_d = tohost_cnt_q;
    end_cycle_d  = end_cycle_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;

    case (state_q)
      ST_HOLDOFF: begin
        if ((HOLDOFF_CYC <= 1) || (hold_cnt_q == c_hold_last)) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + c_hold_w'(1);
        end
      end

      ST_RUN: begin
        cycle_cnt_d  = cycle_nxt;
        instr_cnt_d  = instr_nxt;
        tohost_cnt_d = tohost_nxt;
        // Threshold takes priority over a timeout landing on the same cycle.
        if (thresh_hit) begin
          end_cycle_d = cycle_nxt;
          drain_cnt_d = '0;
          if (DRAIN_CYC == 0) begin
            pass_d  = result_ok;
            fail_d  = !result_ok;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (tmo_hit) begin
          end_cycle_d = cycle_nxt;
          timeout_d   = 1'b1;
          fail_d      = 1'b1;
          pass_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DRAIN: begin
        cycle_cnt_d  = cycle_nxt;
        instr_cnt_d  = instr_nxt;
        tohost_cnt_d = tohost_nxt;
        if (drain_cnt_q == c_drain_last) begin
          pass_d  = result_ok;
          fail_d  = !result_ok;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + c_drain_w'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_HOLDOFF;
      end
    endcase
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q      <= ST_HOLDOFF;
      hold_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      tohost_cnt_q <= '0;
      end_cycle_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      tohost_cnt_q <= tohost_cnt_d;
      end_cycle_q  <= end_cycle_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign instr_cnt  = instr_cnt_q;
  assign tohost_cnt = tohost_cnt_q;
  assign end_cycle  = end_cycle_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire
